hazard_ctrl: RTL and testbench



---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/forward_unit.sv | 30 +++
 rtl/hazard_ctrl.sv | 145 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared types for the 5-stage RISC-V pipeline: forwarding
//               select encoding (also used by the execute-stage operand mux)
//               and hazard controller states.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Execute-stage operand source select
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,    // value read from the register file in ID
        FWD_WB  = 2'b01,    // value being written back from MEM/WB
        FWD_MEM = 2'b10     // ALU result sitting in EX/MEM
    } fwd_sel_e;

    // Hazard controller memory-wait state
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_e;

    // Operand source for one EX source register; the younger producer
    // (EX/MEM) takes precedence over the older one (MEM/WB). x0 never forwards.
    function automatic fwd_sel_e fwd_select(
        input logic [4:0] rs,
        input logic [4:0] ex_mem_rd,
        input logic       ex_mem_we,
        input logic [4:0] mem_wb_rd,
        input logic       mem_wb_we
    );
        fwd_sel_e sel;
        sel = FWD_REG;
        if (ex_mem_we && (ex_mem_rd != 5'd0) && (ex_mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (mem_wb_we && (mem_wb_rd != 5'd0) && (mem_wb_rd == rs)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_unit
// Description : Combinational operand-forwarding selects for the EX stage,
//               one select per source operand (A and B).
// Revision    : 1.0 - initial release
// ============================================================================
module forward_unit
    import riscv_pkg::*;
(
    input  logic [4:0] ID_EX_rs1,
    input  logic [4:0] ID_EX_rs2,
    input  logic [4:0] EX_MEM_rd,
    input  logic       EX_MEM_reg_write,
    input  logic [4:0] MEM_WB_rd,
    input  logic       MEM_WB_reg_write,
    output fwd_sel_e   forwardA,
    output fwd_sel_e   forwardB
);

    // Pick the newest in-flight producer of each EX source register
    always_comb begin
        forwardA = fwd_select(ID_EX_rs1, EX_MEM_rd, EX_MEM_reg_write,
                              MEM_WB_rd, MEM_WB_reg_write);
        forwardB = fwd_select(ID_EX_rs2, EX_MEM_rd, EX_MEM_reg_write,
                              MEM_WB_rd, MEM_WB_reg_write);
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller. Forwarding selects, load-use
//               bubble insertion, taken-branch squash, data-memory freeze,
//               stall/flush performance counters and a sticky memory-timeout
//               debug flag.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import riscv_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       IF_ID_rs1,
    input  logic [4:0]       IF_ID_rs2,
    input  logic [4:0]       ID_EX_rs1,
    input  logic [4:0]       ID_EX_rs2,
    input  logic [4:0]       ID_EX_rd,
    input  logic             ID_EX_mem_read,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             EX_MEM_reg_write,
    input  logic             EX_MEM_mem_read,
    input  logic             EX_MEM_mem_write,
    input  logic [4:0]       MEM_WB_rd,
    input  logic             MEM_WB_reg_write,
    input  logic             branch_taken,
    input  logic             dmem_ready,
    output logic [1:0]       forwardA,
    output logic [1:0]       forwardB,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_hold,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // Wait counter is at least 8 bits, wider if TIMEOUT needs it
    localparam int c_WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT  = c_WAIT_W'(TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_MAX = '1;

    fwd_sel_e            w_fwd_a;
    fwd_sel_e            w_fwd_b;
    logic                w_load_use;
    logic                w_mem_busy;
    hz_state_e           r_state;
    hz_state_e           w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                r_mem_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;
    logic [CNT_W-1:0]    r_flush_cnt;

    forward_unit u_forward_unit (
        .ID_EX_rs1        (ID_EX_rs1),
        .ID_EX_rs2        (ID_EX_rs2),
        .EX_MEM_rd        (EX_MEM_rd),
        .EX_MEM_reg_write (EX_MEM_reg_write),
        .MEM_WB_rd        (MEM_WB_rd),
        .MEM_WB_reg_write (MEM_WB_reg_write),
        .forwardA         (w_fwd_a),
        .forwardB         (w_fwd_b)
    );

    assign forwardA = w_fwd_a;
    assign forwardB = w_fwd_b;

    assign w_load_use = ID_EX_mem_read && (ID_EX_rd != 5'd0) &&
                        ((ID_EX_rd == IF_ID_rs1) || (ID_EX_rd == IF_ID_rs2));
    assign w_mem_busy = (EX_MEM_mem_read || EX_MEM_mem_write) && !dmem_ready;

    // Pipeline control from this cycle's conditions; memory freeze outranks
    // branch squash, which outranks the load-use bubble
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        pipe_hold    = 1'b0;
        if (w_mem_busy) begin
            pipe_hold   = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
        end else if (w_load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end
    end

    // Next state and next wait-counter value
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:      if (w_mem_busy) w_state_nxt = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) w_state_nxt = RUN;
            default:  w_state_nxt = RUN;
        endcase
        w_wait_nxt = r_wait_cnt;
        if (w_state_nxt == RUN) begin
            w_wait_nxt = '0;
        end else if ((r_state == MEM_WAIT) && (r_wait_cnt != c_WAIT_MAX)) begin
            w_wait_nxt = r_wait_cnt + 1'b1;
        end
    end

    // State, wait counter, sticky timeout and performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt >= c_TIMEOUT) begin
                r_mem_timeout <= 1'b1;
            end
            if (!pc_write) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (if_id_flush) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign mem_timeout = r_mem_timeout;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl: directed scenarios
//               followed by random traffic, compared against a behavioural
//               model of the controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int CNT_W   = 32;
    localparam int TIMEOUT = 255;

    logic clk = 1'b0;
    logic reset_n;
    logic [4:0] IF_ID_rs1, IF_ID_rs2, ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
    logic [4:0] EX_MEM_rd, MEM_WB_rd;
    logic ID_EX_mem_read, EX_MEM_reg_write, EX_MEM_mem_read, EX_MEM_mem_write;
    logic MEM_WB_reg_write, branch_taken, dmem_ready;
    logic [1:0] forwardA, forwardB;
    logic pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Model state: counters, whether the controller is waiting on memory,
    // how many further cycles it has spent waiting, sticky timeout
    logic [31:0] m_stall, m_flush;
    bit          m_waiting;
    int          m_wait;
    bit          m_to;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset_n(reset_n),
        .IF_ID_rs1(IF_ID_rs1), .IF_ID_rs2(IF_ID_rs2),
        .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2), .ID_EX_rd(ID_EX_rd),
        .ID_EX_mem_read(ID_EX_mem_read),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write(EX_MEM_reg_write),
        .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_mem_write(EX_MEM_mem_write),
        .MEM_WB_rd(MEM_WB_rd), .MEM_WB_reg_write(MEM_WB_reg_write),
        .branch_taken(branch_taken), .dmem_ready(dmem_ready),
        .forwardA(forwardA), .forwardB(forwardB),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .pipe_hold(pipe_hold), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        IF_ID_rs1 = 0; IF_ID_rs2 = 0; ID_EX_rs1 = 0; ID_EX_rs2 = 0; ID_EX_rd = 0;
        ID_EX_mem_read = 0; EX_MEM_rd = 0; EX_MEM_reg_write = 0;
        EX_MEM_mem_read = 0; EX_MEM_mem_write = 0; MEM_WB_rd = 0;
        MEM_WB_reg_write = 0; branch_taken = 0; dmem_ready = 1;
    endtask

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_waiting = 0; m_wait = 0; m_to = 0;
    endtask

    function automatic int fwd_exp(input logic [4:0] rs);
        if (EX_MEM_reg_write && EX_MEM_rd != 0 && EX_MEM_rd == rs) return 2;
        if (MEM_WB_reg_write && MEM_WB_rd != 0 && MEM_WB_rd == rs) return 1;
        return 0;
    endfunction

    // One clock cycle with the currently driven inputs: check combinational
    // outputs mid-cycle, then registered outputs just after the edge
    task automatic step();
        bit busy, lu, pcw, ifw, fl, bub, hold;
        busy = (EX_MEM_mem_read || EX_MEM_mem_write) && !dmem_ready;
        lu   = ID_EX_mem_read && ID_EX_rd != 0 &&
               (ID_EX_rd == IF_ID_rs1 || ID_EX_rd == IF_ID_rs2);
        hold = busy;
        fl   = !busy && branch_taken;
        bub  = !busy && (branch_taken || lu);
        pcw  = !busy && (branch_taken || !lu);
        ifw  = pcw;
        @(negedge clk);
        chk("forwardA", 32'(forwardA), 32'(fwd_exp(ID_EX_rs1)));
        chk("forwardB", 32'(forwardB), 32'(fwd_exp(ID_EX_rs2)));
        chk("ctrl{pcw,ifw,flush,bubble,hold}",
            32'({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold}),
            32'({pcw, ifw, fl, bub, hold}));
        @(posedge clk);
        #1;
        if (!pcw) m_stall = m_stall + 1;
        if (fl)   m_flush = m_flush + 1;
        if (m_waiting) begin
            if (dmem_ready) begin
                m_waiting = 0;
                m_wait = 0;
            end else if (m_wait < 255) begin
                m_wait++;
            end
        end else if (busy) begin
            m_waiting = 1;
        end
        if (m_wait >= TIMEOUT) m_to = 1;
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        chk("mem_timeout", 32'(mem_timeout), 32'(m_to));
    endtask

    initial begin
        logic [31:0] base;
        // Reset with idle inputs
        set_idle();
        model_reset();
        reset_n = 0;
        #1;
        chk("rst_pc_write", 32'(pc_write), 1);
        chk("rst_if_id_write", 32'(if_id_write), 1);
        chk("rst_others", 32'({forwardA, forwardB, if_id_flush, id_ex_bubble, pipe_hold, mem_timeout}), 0);
        chk("rst_counters", stall_cnt | flush_cnt, 0);
        #22 reset_n = 1;

        // Forwarding priority and x0 exclusion
        EX_MEM_rd = 5; EX_MEM_reg_write = 1; MEM_WB_rd = 5; MEM_WB_reg_write = 1;
        ID_EX_rs1 = 5; ID_EX_rs2 = 6;
        step();
        chk("fwdA_mem_wins", 32'(forwardA), 2);
        EX_MEM_rd = 6;
        step();
        chk("fwdA_wb", 32'(forwardA), 1);
        chk("fwdB_mem", 32'(forwardB), 2);
        EX_MEM_rd = 0; MEM_WB_rd = 0; ID_EX_rs1 = 0; ID_EX_rs2 = 0;
        step();
        chk("fwdA_x0", 32'(forwardA), 0);

        // Load-use: one stall cycle then the bubble clears it
        set_idle();
        base = stall_cnt;
        ID_EX_mem_read = 1; ID_EX_rd = 7; IF_ID_rs2 = 7;
        step();
        ID_EX_mem_read = 0; ID_EX_rd = 0;
        step();
        chk("load_use_stall_delta", stall_cnt - base, 1);
        // Load into x0 never stalls
        ID_EX_mem_read = 1; ID_EX_rd = 0; IF_ID_rs1 = 0;
        step();

        // Branch taken together with load-use: squash wins
        set_idle();
        base = stall_cnt;
        ID_EX_mem_read = 1; ID_EX_rd = 3; IF_ID_rs1 = 3; branch_taken = 1;
        step();
        chk("branch_flush_cnt", flush_cnt, 1);
        chk("branch_no_stall", stall_cnt - base, 0);

        // Memory wait of three cycles, with a pending branch deferred
        set_idle();
        base = stall_cnt;
        EX_MEM_mem_read = 1; dmem_ready = 0; branch_taken = 1;
        repeat (3) step();
        dmem_ready = 1; branch_taken = 0;
        step();
        chk("mem_wait_stall_delta", stall_cnt - base, 3);

        // Long memory wait: sticky timeout
        set_idle();
        EX_MEM_mem_write = 1; dmem_ready = 0;
        repeat (300) step();
        chk("timeout_set", 32'(mem_timeout), 1);
        dmem_ready = 1;
        step();
        set_idle();
        step();
        chk("timeout_sticky", 32'(mem_timeout), 1);

        // Asynchronous reset in the middle of a memory wait
        EX_MEM_mem_read = 1; dmem_ready = 0;
        repeat (3) step();
        #2;
        reset_n = 0;
        set_idle();
        model_reset();
        #1;
        chk("async_rst_counters", stall_cnt | flush_cnt, 0);
        chk("async_rst_timeout", 32'(mem_timeout), 0);
        chk("async_rst_pc_write", 32'(pc_write), 1);
        #10 reset_n = 1;
        // Back in RUN: a short wait must not trip the timeout
        EX_MEM_mem_read = 1; dmem_ready = 0;
        repeat (5) step();
        set_idle();
        step();

        // Random traffic on a small register set to provoke matches
        for (int i = 0; i < 600; i++) begin
            IF_ID_rs1        = 5'($urandom_range(0, 3));
            IF_ID_rs2        = 5'($urandom_range(0, 3));
            ID_EX_rs1        = 5'($urandom_range(0, 3));
            ID_EX_rs2        = 5'($urandom_range(0, 3));
            ID_EX_rd         = 5'($urandom_range(0, 3));
            EX_MEM_rd        = 5'($urandom_range(0, 3));
            MEM_WB_rd        = 5'($urandom_range(0, 3));
            ID_EX_mem_read   = ($urandom_range(0, 2) == 0);
            EX_MEM_reg_write = $urandom_range(0, 1) == 1;
            MEM_WB_reg_write = $urandom_range(0, 1) == 1;
            EX_MEM_mem_read  = ($urandom_range(0, 3) == 0);
            EX_MEM_mem_write = ($urandom_range(0, 5) == 0);
            branch_taken     = ($urandom_range(0, 5) == 0);
            dmem_ready       = ($urandom_range(0, 4) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
